// File: rtl/ifm_win_buf.sv
// rtl/ifm_win_buf.sv - IFM sliding-window buffer between the SRAM reader and the MAC array
//
// Purpose: collects signed IFM samples into a DEPTH-deep shift window and
// offers the whole window to the PE array. A new window is offered after
// DEPTH samples, and then after every stride_q further samples.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   clr             synchronous flush; also latches cfg_stride
//   cfg_stride      new samples per window after the first (0 -> 1, >DEPTH -> DEPTH)
//   in_valid/ready  sample handshake, in_data is the sample
//   win_valid/ready window handshake, win_data slice k = [k*DATA_W +: DATA_W], k=0 newest
//   win_cnt         windows consumed since reset/clr (wraps)
module ifm_win_buf #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 4,
    parameter int STRIDE_W = 3,
    parameter int CNT_W    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic [STRIDE_W-1:0]     cfg_stride,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    output logic                    win_valid,
    input  logic                    win_ready,
    output logic [DEPTH*DATA_W-1:0] win_data,
    output logic [CNT_W-1:0]        win_cnt
);

    // need counts samples still missing before the next window; it never
    // exceeds DEPTH, which fits in STRIDE_W bits because 2**STRIDE_W > DEPTH.
    localparam logic [STRIDE_W-1:0] DEPTH_S = STRIDE_W'(DEPTH);
    localparam logic [STRIDE_W-1:0] ONE_S   = STRIDE_W'(1);

    logic [STRIDE_W-1:0]     need_q, need_d;
    logic [STRIDE_W-1:0]     stride_q, stride_d;
    logic [STRIDE_W-1:0]     stride_lat;
    logic [DEPTH*DATA_W-1:0] win_q, win_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    acc;
    logic                    con;

    assign win_valid = (need_q == '0);
    // In HOLD a sample may only enter when the current window leaves in the
    // same cycle, so the window never changes while it is offered.
    assign in_ready  = (need_q != '0) | win_ready;
    assign acc       = in_valid & in_ready;
    assign con       = win_valid & win_ready;
    assign win_data  = win_q;
    assign win_cnt   = cnt_q;

    always_comb begin
        if (cfg_stride == '0) begin
            stride_lat = ONE_S;
        end else if (cfg_stride > DEPTH_S) begin
            stride_lat = DEPTH_S;
        end else begin
            stride_lat = cfg_stride;
        end
    end

    always_comb begin
        need_d   = need_q;
        stride_d = stride_q;
        win_d    = win_q;
        cnt_d    = cnt_q;
        if (clr) begin
            // Flush wins over any handshake in the same cycle.
            need_d   = DEPTH_S;
            stride_d = stride_lat;
            win_d    = '0;
            cnt_d    = '0;
        end else begin
            if (acc) begin
                win_d = {win_q[(DEPTH-1)*DATA_W-1:0], in_data};
            end
            if (con) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            // A sample arriving with the consume already counts toward the
            // next window, hence stride_q-1.
            if (con && acc) begin
                need_d = stride_q - ONE_S;
            end else if (con) begin
                need_d = stride_q;
            end else if (acc) begin
                need_d = need_q - ONE_S;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            need_q   <= DEPTH_S;
            stride_q <= ONE_S;
            win_q    <= '0;
            cnt_q    <= '0;
        end else begin
            need_q   <= need_d;
            stride_q <= stride_d;
            win_q    <= win_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_ifm_win_buf.sv
// tb/tb_ifm_win_buf.sv - scoreboard bench for ifm_win_buf with a sample-history reference model
module tb_ifm_win_buf;

    localparam int DATA_W   = 8;
    localparam int DEPTH    = 4;
    localparam int STRIDE_W = 3;
    localparam int CNT_W    = 16;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    clr;
    logic [STRIDE_W-1:0]     cfg_stride;
    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_W-1:0]       in_data;
    logic                    win_valid;
    logic                    win_ready;
    logic [DEPTH*DATA_W-1:0] win_data;
    logic [CNT_W-1:0]        win_cnt;

    ifm_win_buf #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .STRIDE_W(STRIDE_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .cfg_stride(cfg_stride),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .win_data  (win_data),
        .win_cnt   (win_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DEPTH*DATA_W-1:0] win;
        logic [CNT_W-1:0]        cnt;
    } exp_t;

    exp_t sb[$];

    // Reference model: window k exists once DEPTH + k*stride samples have
    // been accepted; it holds the most recent DEPTH samples.
    logic [DATA_W-1:0] hist[$];
    int  nacc;
    int  cons;
    int  pushed;
    int  stride_m;
    bit  mvalid;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int clamp_stride(input int c);
        if (c == 0) return 1;
        if (c > DEPTH) return DEPTH;
        return c;
    endfunction

    function automatic logic [DEPTH*DATA_W-1:0] model_window();
        logic [DEPTH*DATA_W-1:0] w;
        w = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w[k*DATA_W +: DATA_W] = hist[hist.size()-1-k];
        end
        return w;
    endfunction

    task automatic model_reset(input int s);
        hist.delete();
        sb.delete();
        nacc     = 0;
        cons     = 0;
        pushed   = 0;
        stride_m = s;
        mvalid   = 1'b0;
    endtask

    // One clock cycle of stimulus; called at posedge+1.
    task automatic cycle(input bit v, input logic [DATA_W-1:0] d, input bit wr,
                         input bit c, input logic [STRIDE_W-1:0] cfg);
        exp_t e;
        bit   exp_ready;
        in_valid   = v;
        in_data    = d;
        win_ready  = wr;
        clr        = c;
        cfg_stride = cfg;
        #2;
        exp_ready = !mvalid || wr;
        check("in_ready", 64'(in_ready), 64'(exp_ready));
        @(posedge clk);
        if (c) begin
            model_reset(clamp_stride(int'(cfg)));
        end else begin
            if (mvalid && wr) cons++;
            if (v && exp_ready) begin
                hist.push_back(d);
                nacc++;
                if (hist.size() > DEPTH) void'(hist.pop_front());
            end
            mvalid = (nacc >= DEPTH + cons * stride_m);
            if (mvalid && pushed == cons) begin
                e.win = model_window();
                e.cnt = CNT_W'(cons);
                sb.push_back(e);
                pushed++;
            end
        end
        #1;
        check("win_valid", 64'(win_valid), 64'(mvalid));
        check("win_cnt", 64'(win_cnt), 64'(CNT_W'(cons)));
        if (mvalid && sb.size() > 0) check("win_hold", 64'(win_data), 64'(sb[0].win));
        if (c) check("clr_win_zero", 64'(win_data), 64'h0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT hands over a window.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && !clr && win_valid && win_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_underflow actual=window expected=none at %0t", $time);
                end else begin
                    e = sb.pop_front();
                    check("win_data", 64'(win_data), 64'(e.win));
                    check("con_cnt", 64'(win_cnt), 64'(e.cnt));
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        clr        = 1'b0;
        cfg_stride = '0;
        in_valid   = 1'b0;
        in_data    = '0;
        win_ready  = 1'b0;
        model_reset(1);
        repeat (2) @(posedge clk);
        #2;
        check("rst_win_valid", 64'(win_valid), 64'h0);
        check("rst_in_ready", 64'(in_ready), 64'h1);
        check("rst_win_data", 64'(win_data), 64'h0);
        check("rst_win_cnt", 64'(win_cnt), 64'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Fill 1,2,3,4 at stride 1 with the consumer always ready.
        for (int i = 1; i <= 4; i++) cycle(1'b1, DATA_W'(i), 1'b1, 1'b0, '0);
        check("t1_first_window", 64'(win_data), 64'h01020304);
        for (int i = 5; i <= 8; i++) cycle(1'b1, DATA_W'(i), 1'b1, 1'b0, '0);
        cycle(1'b0, '0, 1'b1, 1'b0, '0);

        // Stride 2: first window 1..4, then 5,6 -> 6,5,4,3.
        cycle(1'b0, '0, 1'b0, 1'b1, 3'd2);
        for (int i = 1; i <= 4; i++) cycle(1'b1, DATA_W'(i), 1'b0, 1'b0, '0);
        cycle(1'b1, 8'd5, 1'b1, 1'b0, '0);
        check("t2_fill_gap", 64'(win_valid), 64'h0);
        cycle(1'b1, 8'd6, 1'b0, 1'b0, '0);
        check("t2_second_window", 64'(win_data), 64'h03040506);

        // Backpressure: full window, sample waiting for 5 cycles.
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'hA5, 1'b0, 1'b0, '0);
        cycle(1'b1, 8'hA5, 1'b1, 1'b0, '0);
        cycle(1'b1, 8'hA6, 1'b0, 1'b0, '0);
        check("t3_sample_kept", 64'(win_data), 64'h0506A5A6);

        // Negative samples, bit exact.
        cycle(1'b0, '0, 1'b0, 1'b1, 3'd1);
        cycle(1'b1, 8'h80, 1'b0, 1'b0, '0);
        cycle(1'b1, 8'hFF, 1'b0, 1'b0, '0);
        cycle(1'b1, 8'h7F, 1'b0, 1'b0, '0);
        cycle(1'b1, 8'h00, 1'b0, 1'b0, '0);
        check("t4_negative", 64'(win_data), 64'h80FF7F00);

        // clr colliding with both handshakes; stride 7 clamps to 4.
        cycle(1'b1, 8'h11, 1'b1, 1'b1, 3'd7);
        check("t5_clr_valid", 64'(win_valid), 64'h0);
        for (int i = 0; i < 12; i++) cycle(1'b1, DATA_W'(32 + i), 1'b1, 1'b0, '0);
        cycle(1'b1, 8'h22, 1'b1, 1'b1, 3'd0);
        for (int i = 0; i < 8; i++) cycle(1'b1, DATA_W'(64 + i), 1'b1, 1'b0, '0);

        // Async reset between edges after two samples of a fill.
        cycle(1'b0, '0, 1'b0, 1'b1, 3'd1);
        cycle(1'b1, 8'h01, 1'b0, 1'b0, '0);
        cycle(1'b1, 8'h02, 1'b0, 1'b0, '0);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_need", 64'(in_ready), 64'h1);
        check("t6_rst_data", 64'(win_data), 64'h0);
        check("t6_rst_valid", 64'(win_valid), 64'h0);
        model_reset(1);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Random traffic with occasional reconfiguration.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                cycle($urandom_range(0, 1) == 1, DATA_W'($urandom), $urandom_range(0, 1) == 1,
                      1'b1, STRIDE_W'($urandom_range(0, 7)));
            end else begin
                cycle($urandom_range(0, 3) != 0, DATA_W'($urandom), $urandom_range(0, 2) != 0,
                      1'b0, '0);
            end
        end
        cycle(1'b0, '0, 1'b0, 1'b0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
